sd_rx_word_packer: RTL and testbench



---
 rtl/sd_pkg.sv | 29 ++
 rtl/sd_word_buf2.sv | 51 +++++
 rtl/sd_rx_word_packer.sv | 136 +++++++++++++
 tb/tb_sd_rx_word_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD receive-path constants, packer state encoding and nibble placement helper.
package sd_pkg;

  localparam int SD_BUS_W        = 4;
  localparam int BLOCK_WORDS_DEF = 128;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_COLLECT = 4'b0010,
    ST_FLUSH   = 4'b0100,
    ST_DRAIN   = 4'b1000
  } pk_state_t;

  // Big-endian puts nibble 0 in [31:28]; little-endian puts it in [3:0].
  function automatic logic [31:0] nib_insert(
    input logic [31:0]         word,
    input logic [2:0]          idx,
    input logic [SD_BUS_W-1:0] nib,
    input logic                big_endian
  );
    logic [31:0] w;
    logic [2:0]  pos;
    w   = word;
    pos = big_endian ? (3'd7 - idx) : idx;
    w[{pos, 2'b00} +: SD_BUS_W] = nib;
    return w;
  endfunction

endpackage

// File: rtl/sd_word_buf2.sv
// Two-entry word holding buffer; a push while full without a pop is dropped and flagged.
// Head/count are registered; a pop frees a slot for a push on the same edge.
module sd_word_buf2 (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [31:0] push_dat,
  input  logic        pop,
  output logic [31:0] head,
  output logic [1:0]  count,
  output logic        drop
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sd_rx_word_packer.sv
// Packs SD read nibbles into 32-bit words for the RX FIFO; word written the edge after its 8th nibble.
// fifo_full stalls the 2-entry buffer; a third word arriving while stalled is dropped (overflow).
module sd_rx_word_packer
  import sd_pkg::*;
#(
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int CW          = $clog2(BLOCK_WORDS + 1)
) (
  input  logic                sd_clk,
  input  logic                rst,
  input  logic [SD_BUS_W-1:0] nib_in,
  input  logic                nib_we,
  input  logic                blk_done,
  input  logic                abort,
  output logic [31:0]         fifo_din,
  output logic                fifo_we,
  input  logic                fifo_full,
  output logic [CW-1:0]       word_cnt,
  output logic                blk_ready,
  output logic                overflow,
  output logic                len_err
);

  pk_state_t   state;
  pk_state_t   state_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_after;
  logic [31:0] asm_word;
  logic [31:0] ins_word;
  logic        nib_acc;
  logic        nib_ovr;
  logic        start;
  logic        flush;
  logic        push;
  logic [31:0] push_dat;
  logic        drop;
  logic [1:0]  buf_cnt;
  logic        cnt_full;
  logic        drain_end;

  assign cnt_full  = (word_cnt == CW'(BLOCK_WORDS));
  assign ins_word  = nib_insert(asm_word, idx, nib_in, BIG_ENDIAN);
  assign flush     = (state == ST_FLUSH);
  assign drain_end = (state == ST_DRAIN) && (buf_cnt == 2'd0);
  assign push      = (nib_acc && (idx == 3'd7)) || flush;
  assign push_dat  = flush ? asm_word : ins_word;
  assign fifo_we   = (buf_cnt != 2'd0) && !fifo_full && !abort;

  always_comb begin
    state_nxt = state;
    nib_acc   = 1'b0;
    nib_ovr   = 1'b0;
    start     = 1'b0;
    idx_after = idx;
    case (state)
      ST_IDLE: begin
        if (nib_we) begin
          start     = 1'b1;
          nib_acc   = 1'b1;
          state_nxt = blk_done ? ST_FLUSH : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (nib_we) begin
          if (cnt_full && (idx == 3'd0)) nib_ovr = 1'b1;
          else                           nib_acc = 1'b1;
        end
        // the flush decision sees the index after this cycle's nibble
        idx_after = nib_acc ? (idx + 3'd1) : idx;
        if (blk_done) state_nxt = (idx_after != 3'd0) ? ST_FLUSH : ST_DRAIN;
      end
      ST_FLUSH: state_nxt = ST_DRAIN;
      ST_DRAIN: if (buf_cnt == 2'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  sd_word_buf2 u_buf (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .clr      (abort),
    .push     (push),
    .push_dat (push_dat),
    .pop      (fifo_we),
    .head     (fifo_din),
    .count    (buf_cnt),
    .drop     (drop)
  );

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      asm_word  <= '0;
      word_cnt  <= '0;
      blk_ready <= 1'b0;
      overflow  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      blk_ready <= 1'b0;
      if (abort) begin
        idx      <= 3'd0;
        asm_word <= '0;
        overflow <= 1'b0;
        len_err  <= 1'b0;
      end else begin
        // a completed word leaves the register zeroed so a flush pads with zeros
        if (nib_acc) begin
          idx      <= idx + 3'd1;
          asm_word <= (idx == 3'd7) ? '0 : ins_word;
        end
        if (flush) begin
          idx      <= 3'd0;
          asm_word <= '0;
        end
        if (start)              word_cnt <= '0;
        else if (push && !drop) word_cnt <= word_cnt + CW'(1);
        if (start) begin
          overflow <= 1'b0;
          len_err  <= 1'b0;
        end else begin
          if (drop)    overflow <= 1'b1;
          if (nib_ovr) len_err  <= 1'b1;
          if (drain_end) begin
            blk_ready <= 1'b1;
            if (!cnt_full) len_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_rx_word_packer.sv
// Directed bench: expected FIFO words are queued as stimulus is issued; a monitor pops them on each write.
module tb_sd_rx_word_packer;

  localparam int CW = $clog2(128 + 1);

  logic          sd_clk;
  logic          rst;
  logic [3:0]    nib_in;
  logic          nib_we;
  logic          blk_done;
  logic          abort;
  logic          fifo_full;
  logic [31:0]   fifo_din;
  logic          fifo_we;
  logic [CW-1:0] word_cnt;
  logic          blk_ready;
  logic          overflow;
  logic          len_err;
  logic [31:0]   le_fifo_din;
  logic          le_fifo_we;
  logic [CW-1:0] le_word_cnt;
  logic          le_blk_ready;
  logic          le_overflow;
  logic          le_len_err;

  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  int            wr_cnt   = 0;
  int            rdy_cnt  = 0;
  int            full_left = 0;
  logic [31:0]   exp_q[$];

  sd_rx_word_packer #(.BIG_ENDIAN(1'b1)) u_dut (
    .sd_clk(sd_clk), .rst(rst), .nib_in(nib_in), .nib_we(nib_we), .blk_done(blk_done),
    .abort(abort), .fifo_din(fifo_din), .fifo_we(fifo_we), .fifo_full(fifo_full),
    .word_cnt(word_cnt), .blk_ready(blk_ready), .overflow(overflow), .len_err(len_err)
  );

  sd_rx_word_packer #(.BIG_ENDIAN(1'b0)) u_dut_le (
    .sd_clk(sd_clk), .rst(rst), .nib_in(nib_in), .nib_we(nib_we), .blk_done(blk_done),
    .abort(abort), .fifo_din(le_fifo_din), .fifo_we(le_fifo_we), .fifo_full(fifo_full),
    .word_cnt(le_word_cnt), .blk_ready(le_blk_ready), .overflow(le_overflow), .len_err(le_len_err)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Writes happen on the posedge following a negedge+2 sample with fifo_we high.
  always @(negedge sd_clk) begin
    #2;
    if (rst === 1'b1 && fifo_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got %h expected no write", fifo_din);
      end else begin
        chk("fifo_din", fifo_din, exp_q.pop_front());
      end
    end
    if (rst === 1'b1 && blk_ready === 1'b1) rdy_cnt++;
  end

  task automatic tick();
    fifo_full = (full_left > 0);
    if (full_left > 0) full_left--;
    @(negedge sd_clk);
  endtask

  task automatic nib(input logic [3:0] v);
    nib_in = v;
    nib_we = 1'b1;
    tick();
    nib_we = 1'b0;
  endtask

  task automatic done_pulse();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int start;
    start = rdy_cnt;
    for (int i = 0; i < bound; i++) begin
      tick();
      #3;
      if (rdy_cnt != start) break;
    end
    repeat (3) tick();
    chk(name, rdy_cnt, start + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    rst = 1'b0; nib_in = '0; nib_we = 1'b0; blk_done = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge sd_clk);
    #3;
    chk("rst_fifo_we", fifo_we, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_len_err", len_err, 0);
    @(negedge sd_clk);
    rst = 1'b1;
    tick();

    // full 128-word block, nibbles 0..F repeating
    w0 = wr_cnt;
    for (int n = 0; n < 1024; n++) begin
      if (n % 8 == 0) exp_q.push_back(((n / 8) % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);
      nib(n[3:0]);
    end
    done_pulse();
    wait_ready("full_blk_ready", 20);
    #3;
    chk("full_word_cnt", word_cnt, 128);
    chk("full_len_err", len_err, 0);
    chk("full_overflow", overflow, 0);
    chk("full_writes", wr_cnt - w0, 128);
    @(negedge sd_clk);

    // little-endian word, also a short block on the big-endian instance
    exp_q.push_back(32'h12345678);
    for (int n = 1; n <= 8; n++) nib(n[3:0]);
    #3;
    chk("le_fifo_we", le_fifo_we, 1);
    chk("le_fifo_din", le_fifo_din, 32'h87654321);
    chk("le_word_cnt", le_word_cnt, 1);
    chk("restart_word_cnt", word_cnt, 1);
    @(negedge sd_clk);
    done_pulse();
    wait_ready("le_blk_ready", 20);
    #3;
    chk("le_blk_len_err", len_err, 1);
    @(negedge sd_clk);

    // short block with zero-padded flush
    w0 = wr_cnt;
    exp_q.push_back(32'hABCDEF12);
    exp_q.push_back(32'h34560000);
    nib(4'hA);
    #3;
    chk("start_clears_len_err", len_err, 0);
    chk("start_clears_cnt", word_cnt, 0);
    @(negedge sd_clk);
    for (int n = 11; n <= 15; n++) nib(n[3:0]);
    for (int n = 1; n <= 6; n++) nib(n[3:0]);
    done_pulse();
    wait_ready("short_blk_ready", 20);
    #3;
    chk("short_len_err", len_err, 1);
    chk("short_word_cnt", word_cnt, 2);
    chk("short_writes", wr_cnt - w0, 2);
    @(negedge sd_clk);

    // blk_done on the same edge as the 8th nibble
    w0 = wr_cnt;
    exp_q.push_back(32'h12345678);
    for (int n = 1; n <= 7; n++) nib(n[3:0]);
    blk_done = 1'b1;
    nib(4'h8);
    blk_done = 1'b0;
    wait_ready("same_edge_ready", 20);
    #3;
    chk("same_edge_writes", wr_cnt - w0, 1);
    chk("same_edge_word_cnt", word_cnt, 1);
    @(negedge sd_clk);

    // 16 cycles of fifo_full absorbed, 17 drop the third word
    for (int l = 16; l <= 17; l++) begin
      w0 = wr_cnt;
      for (int n = 0; n < 32; n++) begin
        if (n % 8 == 0 && !(l == 17 && n == 16))
          exp_q.push_back(((n / 8) % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);
        if (n == 7) full_left = l;
        nib(n[3:0]);
      end
      done_pulse();
      wait_ready((l == 16) ? "bp16_ready" : "bp17_ready", 40);
      #3;
      chk((l == 16) ? "bp16_overflow" : "bp17_overflow", overflow, (l == 16) ? 0 : 1);
      chk((l == 16) ? "bp16_word_cnt" : "bp17_word_cnt", word_cnt, (l == 16) ? 4 : 3);
      chk((l == 16) ? "bp16_writes" : "bp17_writes", wr_cnt - w0, (l == 16) ? 4 : 3);
      @(negedge sd_clk);
    end

    // abort mid-word with the buffer full
    w0 = wr_cnt;
    full_left = 10000;
    for (int n = 0; n < 27; n++) nib(n[3:0]);
    #3;
    chk("pre_abort_overflow", overflow, 1);
    @(negedge sd_clk);
    full_left = 0;
    fifo_full = 1'b0;
    abort = 1'b1;
    #3;
    chk("abort_cycle_we", fifo_we, 0);
    @(negedge sd_clk);
    abort = 1'b0;
    #3;
    chk("abort_clears_overflow", overflow, 0);
    chk("abort_no_we", fifo_we, 0);
    @(negedge sd_clk);
    w0 = rdy_cnt;
    repeat (6) tick();
    #3;
    chk("abort_no_ready", rdy_cnt, w0);
    @(negedge sd_clk);
    exp_q.push_back(32'h12345678);
    for (int n = 1; n <= 8; n++) nib(n[3:0]);
    #3;
    chk("post_abort_word_cnt", word_cnt, 1);
    @(negedge sd_clk);
    done_pulse();
    wait_ready("post_abort_ready", 20);

    // asynchronous reset mid-block
    full_left = 10000;
    for (int n = 0; n < 11; n++) nib(n[3:0]);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_fifo_we", fifo_we, 0);
    chk("arst_fifo_din", fifo_din, 0);
    chk("arst_word_cnt", word_cnt, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_len_err", len_err, 0);
    chk("arst_blk_ready", blk_ready, 0);
    full_left = 0;
    fifo_full = 1'b0;
    @(negedge sd_clk);
    rst = 1'b1;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
